// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer time-sharing one combinational ALU between two requesters
module alu_share_ctrl #(
   parameter int DW = 8,
   parameter int CW = 8
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_req0_valid,
   input  logic [1:0]    i_req0_fn,
   input  logic [DW-1:0] i_req0_a,
   input  logic [DW-1:0] i_req0_b,
   output logic          o_req0_ready,
   input  logic          i_req1_valid,
   input  logic [1:0]    i_req1_fn,
   input  logic [DW-1:0] i_req1_a,
   input  logic [DW-1:0] i_req1_b,
   output logic          o_req1_ready,
   output logic [1:0]    o_alu_fn,
   output logic [DW-1:0] o_alu_a,
   output logic [DW-1:0] o_alu_b,
   input  logic [DW-1:0] i_alu_sum,
   input  logic          i_alu_s,
   input  logic          i_alu_v,
   input  logic          i_alu_n,
   input  logic          i_alu_z,
   output logic          o_rsp_valid,
   input  logic          i_rsp_ready,
   output logic          o_rsp_id,
   output logic [DW-1:0] o_rsp_sum,
   output logic [3:0]    o_rsp_flags,
   output logic          o_busy,
   output logic [CW-1:0] o_op_count
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t        r_state;
   logic          r_last;
   logic          r_id;
   logic [1:0]    r_alu_fn;
   logic [DW-1:0] r_alu_a;
   logic [DW-1:0] r_alu_b;
   logic          r_rsp_valid;
   logic          r_rsp_id;
   logic [DW-1:0] r_rsp_sum;
   logic [3:0]    r_rsp_flags;
   logic [CW-1:0] r_op_count;
   logic          w_idle;
   logic          w_gnt0;
   logic          w_gnt1;
   // on a tie the requester that did not win last time gets the grant
   always_comb begin
      w_idle = r_state == IDLE;
      w_gnt0 = i_req0_valid & (~i_req1_valid | r_last);
      w_gnt1 = i_req1_valid & (~i_req0_valid | ~r_last);
   end
   assign o_req0_ready = i_rst_n & w_idle & w_gnt0;
   assign o_req1_ready = i_rst_n & w_idle & w_gnt1;
   assign o_busy       = ~w_idle;
   assign o_alu_fn     = r_alu_fn;
   assign o_alu_a      = r_alu_a;
   assign o_alu_b      = r_alu_b;
   assign o_rsp_valid  = r_rsp_valid;
   assign o_rsp_id     = r_rsp_id;
   assign o_rsp_sum    = r_rsp_sum;
   assign o_rsp_flags  = r_rsp_flags;
   assign o_op_count   = r_op_count;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_last      <= 1'b1;
         r_id        <= 1'b0;
         r_alu_fn    <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_sum   <= '0;
         r_rsp_flags <= '0;
         r_op_count  <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_gnt0 | w_gnt1) begin
               r_alu_fn <= w_gnt1 ? i_req1_fn : i_req0_fn;
               r_alu_a  <= w_gnt1 ? i_req1_a : i_req0_a;
               r_alu_b  <= w_gnt1 ? i_req1_b : i_req0_b;
               r_id     <= w_gnt1;
               r_last   <= w_gnt1;
               r_state  <= EXEC;
            end
            EXEC: begin
               r_rsp_sum   <= i_alu_sum;
               r_rsp_flags <= {i_alu_s, i_alu_v, i_alu_n, i_alu_z};
               r_rsp_id    <= r_id;
               r_rsp_valid <= 1'b1;
               r_state     <= RESP;
            end
            RESP: if (i_rsp_ready) begin
               r_rsp_valid <= 1'b0;
               r_op_count  <= r_op_count + CW'(1);
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: scoreboard bench for alu_share_ctrl with a behavioural ALU, counter width 2
module tb_alu_share_ctrl;
   localparam int DW = 8;
   localparam int CW = 2;
   typedef struct packed {
      logic          id;
      logic [DW-1:0] sum;
      logic [3:0]    fl;
   } rsp_t;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0_valid, req1_valid, req0_ready, req1_ready;
   logic [1:0]    req0_fn, req1_fn, alu_fn;
   logic [DW-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_sum;
   logic          alu_s, alu_v, alu_n, alu_z;
   logic          rsp_valid, rsp_ready, rsp_id, busy;
   logic [DW-1:0] rsp_sum;
   logic [3:0]    rsp_flags;
   logic [CW-1:0] op_count;
   logic [CW-1:0] exp_cnt;
   rsp_t          q[$];
   rsp_t          mon_r;
   int            tests = 0;
   int            fails = 0;
   always #5 clk = ~clk;
   always_comb begin
      alu_sum = alu_fn == 2'b00 ? alu_a & alu_b : alu_fn == 2'b01 ? alu_a | alu_b :
                alu_fn == 2'b10 ? alu_a ^ alu_b : ~alu_a;
      alu_s = alu_sum[DW-1];
      alu_v = 1'b0;
      alu_n = alu_sum[DW-1];
      alu_z = ~|alu_sum;
   end
   alu_share_ctrl #(.DW(DW), .CW(CW)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req0_valid(req0_valid), .i_req0_fn(req0_fn), .i_req0_a(req0_a), .i_req0_b(req0_b),
      .o_req0_ready(req0_ready),
      .i_req1_valid(req1_valid), .i_req1_fn(req1_fn), .i_req1_a(req1_a), .i_req1_b(req1_b),
      .o_req1_ready(req1_ready),
      .o_alu_fn(alu_fn), .o_alu_a(alu_a), .o_alu_b(alu_b),
      .i_alu_sum(alu_sum), .i_alu_s(alu_s), .i_alu_v(alu_v), .i_alu_n(alu_n), .i_alu_z(alu_z),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
      .o_rsp_sum(rsp_sum), .o_rsp_flags(rsp_flags), .o_busy(busy), .o_op_count(op_count)
   );
   function automatic rsp_t expect_rsp(input logic id, input logic [1:0] fn, input logic [DW-1:0] a, b);
      logic [DW-1:0] s;
      s = fn == 2'b00 ? a & b : fn == 2'b01 ? a | b : fn == 2'b10 ? a ^ b : ~a;
      return {id, s, s[DW-1], 1'b0, s[DW-1], ~|s};
   endfunction
   task automatic run_op(input logic sel, input logic [1:0] fn, input logic [DW-1:0] a, b,
                         output logic ok, output rsp_t got);
      ok = 1'b0;
      got = '0;
      @(posedge clk); #2;
      if (sel) begin req1_valid = 1'b1; req1_fn = fn; req1_a = a; req1_b = b; end
      else begin req0_valid = 1'b1; req0_fn = fn; req0_a = a; req0_b = b; end
      for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = sel ? req1_ready : req0_ready; end
      if (!ok) begin req0_valid = 1'b0; req1_valid = 1'b0; return; end
      @(posedge clk); #2;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = rsp_valid; end
      got = {rsp_id, rsp_sum, rsp_flags};
   endtask
   task automatic wait_idle(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin @(negedge clk); ok = !busy && !rsp_valid; end
   endtask
   task automatic test_reset;
      rst_n = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if ({req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_sum, rsp_flags, alu_fn, alu_a, alu_b, op_count} !== '0) begin
         fails++;
         $display("FAIL reset_state: rdy=%b%b busy=%b rv=%b id=%b sum=%h fl=%b fn=%b a=%h b=%h cnt=%0d, required all 0",
                  req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_sum, rsp_flags, alu_fn, alu_a, alu_b, op_count);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
   endtask
   task automatic test_single;
      rsp_ready = 1'b1;
      @(posedge clk); #2;
      req0_valid = 1'b1; req0_fn = 2'b00; req0_a = 8'hF0; req0_b = 8'h3C;
      @(negedge clk);
      tests++;
      if ({req0_ready, req1_ready, busy} !== 3'b100) begin
         fails++;
         $display("FAIL single_accept: ready0/ready1/busy=%b, required 100", {req0_ready, req1_ready, busy});
      end
      @(posedge clk); #2;
      req0_valid = 1'b0;
      @(negedge clk);
      tests++;
      if ({rsp_valid, busy, alu_fn, alu_a, alu_b} !== {1'b0, 1'b1, 2'b00, 8'hF0, 8'h3C}) begin
         fails++;
         $display("FAIL single_exec: rv=%b busy=%b fn=%b a=%h b=%h, required rv=0 busy=1 fn=00 a=f0 b=3c",
                  rsp_valid, busy, alu_fn, alu_a, alu_b);
      end
      @(negedge clk);
      tests++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_flags} !== {1'b1, 1'b0, 8'h30, 4'b0000}) begin
         fails++;
         $display("FAIL single_rsp: rv=%b id=%b sum=%h fl=%b, required rv=1 id=0 sum=30 fl=0000",
                  rsp_valid, rsp_id, rsp_sum, rsp_flags);
      end
      @(negedge clk);
      tests++;
      if ({rsp_valid, busy, op_count} !== {1'b0, 1'b0, 2'd1}) begin
         fails++;
         $display("FAIL single_done: rv=%b busy=%b cnt=%0d, required rv=0 busy=0 cnt=1", rsp_valid, busy, op_count);
      end
   endtask
   task automatic test_flags;
      logic ok;
      rsp_t got;
      run_op(1'b1, 2'b10, 8'hA5, 8'hA5, ok, got);
      tests++;
      if (!ok || got !== {1'b1, 8'h00, 4'b0001}) begin
         fails++;
         $display("FAIL flags_zero: ok=%b got=%h, required ok=1 rsp=%h", ok, got, {1'b1, 8'h00, 4'b0001});
      end
      run_op(1'b1, 2'b11, 8'h00, 8'h12, ok, got);
      tests++;
      if (!ok || got !== {1'b1, 8'hFF, 4'b1010}) begin
         fails++;
         $display("FAIL flags_sign: ok=%b got=%h, required ok=1 rsp=%h", ok, got, {1'b1, 8'hFF, 4'b1010});
      end
   endtask
   task automatic test_rr;
      int   n = 0;
      logic ok;
      @(posedge clk); #2;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_fn = 2'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_fn = 2'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
      for (int c = 0; c < 60 && n < 6; c++) begin
         @(negedge clk);
         tests++;
         if (req0_ready && req1_ready) begin
            fails++;
            $display("FAIL rr_exclusive: both readies high at cycle %0d, required at most one", c);
         end
         if (req0_ready || req1_ready) begin
            tests++;
            if (req1_ready !== n[0]) begin
               fails++;
               $display("FAIL rr_grant: grant %0d went to %0d, required %0d", n, req1_ready, n[0]);
            end
            n++;
            @(posedge clk); #2;
            req0_fn = 2'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
            req1_fn = 2'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_idle(ok);
      tests++;
      if (n != 6 || !ok) begin
         fails++;
         $display("FAIL rr_count: %0d grants idle=%b, required 6 grants and idle", n, ok);
      end
   endtask
   task automatic test_backpressure;
      logic          ok = 1'b0;
      rsp_t          snap;
      logic [CW-1:0] cnt0;
      @(posedge clk); #2;
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_fn = 2'b00; req0_a = 8'h5A; req0_b = 8'hFF;
      for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = req0_ready; end
      @(posedge clk); #2;
      req1_valid = 1'b1; req1_fn = 2'b01; req1_a = 8'h11; req1_b = 8'h22;
      req0_a = 8'h77;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = rsp_valid; end
      snap = {rsp_id, rsp_sum, rsp_flags};
      cnt0 = op_count;
      tests++;
      if (!ok || snap !== {1'b0, 8'h5A, 4'b0000}) begin
         fails++;
         $display("FAIL bp_rsp: ok=%b rsp=%h, required ok=1 rsp=%h", ok, snap, {1'b0, 8'h5A, 4'b0000});
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (!rsp_valid || {rsp_id, rsp_sum, rsp_flags} !== snap || req0_ready || req1_ready || !busy) begin
            fails++;
            $display("FAIL bp_hold: cycle %0d rv=%b rsp=%h rdy=%b%b busy=%b, required rv=1 rsp=%h rdy=00 busy=1",
                     i, rsp_valid, {rsp_id, rsp_sum, rsp_flags}, req0_ready, req1_ready, busy, snap);
         end
      end
      @(posedge clk); #2;
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if ({rsp_valid, busy, op_count} !== {1'b0, 1'b0, cnt0 + 2'd1}) begin
         fails++;
         $display("FAIL bp_release: rv=%b busy=%b cnt=%0d, required rv=0 busy=0 cnt=%0d",
                  rsp_valid, busy, op_count, cnt0 + 2'd1);
      end
      @(negedge clk);
      tests++;
      if (op_count !== cnt0 + 2'd1) begin
         fails++;
         $display("FAIL bp_once: cnt=%0d, required %0d", op_count, cnt0 + 2'd1);
      end
   endtask
   task automatic test_reset_mid;
      logic ok = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #2;
      req0_valid = 1'b1; req0_fn = 2'b01; req0_a = 8'hC3; req0_b = 8'h0C;
      for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = req0_ready; end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (!ok || {req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_sum, rsp_flags, alu_fn, alu_a, alu_b, op_count} !== '0) begin
         fails++;
         $display("FAIL reset_async: acc=%b rdy=%b%b busy=%b rv=%b fn=%b a=%h b=%h cnt=%0d, required acc=1 and all 0",
                  ok, req0_ready, req1_ready, busy, rsp_valid, alu_fn, alu_a, alu_b, op_count);
      end
      @(negedge clk);
      @(posedge clk); #2;
      req0_valid = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++;
         if (rsp_valid || busy) begin
            fails++;
            $display("FAIL reset_no_rsp: cycle %0d rv=%b busy=%b, required 0 0", i, rsp_valid, busy);
         end
      end
      @(posedge clk); #2;
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      tests++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         fails++;
         $display("FAIL reset_grant: ready0/ready1=%b, required 10", {req0_ready, req1_ready});
      end
      @(posedge clk); #2;
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_idle(ok);
   endtask
   task automatic test_wrap;
      logic       ok;
      rsp_t       got;
      logic [1:0] exp_seq[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      @(posedge clk); #2;
      rst_n = 1'b0;
      @(negedge clk);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (op_count !== 2'd0) begin
         fails++;
         $display("FAIL wrap_start: cnt=%0d, required 0", op_count);
      end
      for (int i = 0; i < 5; i++) begin
         run_op(i[0], 2'(i), 8'(8'h1F * i), 8'h96, ok, got);
         @(negedge clk);
         tests++;
         if (!ok || op_count !== exp_seq[i]) begin
            fails++;
            $display("FAIL wrap_count: op %0d ok=%b cnt=%0d, required ok=1 cnt=%0d", i, ok, op_count, exp_seq[i]);
         end
      end
   endtask
   initial begin
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      req0_fn = '0; req0_a = '0; req0_b = '0;
      req1_fn = '0; req1_a = '0; req1_b = '0;
      exp_cnt = '0;
      fork
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               q.delete();
               exp_cnt = '0;
            end else begin
               tests++;
               if (op_count !== exp_cnt) begin
                  fails++;
                  $display("FAIL sb_count: cnt=%0d, required %0d", op_count, exp_cnt);
               end
               if (req0_valid && req0_ready) q.push_back(expect_rsp(1'b0, req0_fn, req0_a, req0_b));
               if (req1_valid && req1_ready) q.push_back(expect_rsp(1'b1, req1_fn, req1_a, req1_b));
               if (rsp_valid && rsp_ready) begin
                  tests++;
                  if (q.size() == 0) begin
                     fails++;
                     $display("FAIL sb_rsp: got %h with nothing outstanding", {rsp_id, rsp_sum, rsp_flags});
                  end else begin
                     mon_r = q.pop_front();
                     if ({rsp_id, rsp_sum, rsp_flags} !== mon_r) begin
                        fails++;
                        $display("FAIL sb_rsp: got %h, required %h", {rsp_id, rsp_sum, rsp_flags}, mon_r);
                     end
                  end
                  exp_cnt = exp_cnt + 2'd1;
               end
            end
         end
      join_none
      test_reset();
      test_single();
      test_flags();
      test_rr();
      test_backpressure();
      test_reset_mid();
      test_wrap();
      repeat (3) @(negedge clk);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL sb_drain: %0d responses outstanding, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
